// File: rtl/ddr_deser_pkg.sv
// ddr_deser_pkg: shared constants for the DDR input deserialiser.
//   DDR_DESER_SEARCH  hunting for the sync word at either bit phase
//   DDR_DESER_LOCKED  word phase fixed, one word every W/2 clocks
//   PHASE_A / PHASE_B selected candidate (word ends on fall / on rise bit)
package ddr_deser_pkg;

   localparam logic [0:0] DDR_DESER_SEARCH = 1'b0;
   localparam logic [0:0] DDR_DESER_LOCKED = 1'b1;

   localparam logic PHASE_A = 1'b0;
   localparam logic PHASE_B = 1'b1;

endpackage

// File: rtl/ddr_deser_iddr.sv
// iddr_pin: registered DDR input capture for one data pin
module iddr_pin (
  input  logic       i_clk,
  input  logic       i_pin,
  output logic [1:0] o_pair
);
  logic rise, fall;
`ifdef DDR_DESER_USE_SB_IO
  SB_IO #(
    .PIN_TYPE (6'b000000),
    .PULLUP   (1'b0)
  ) u_io (
    .PACKAGE_PIN       (i_pin),
    .LATCH_INPUT_VALUE (1'b0),
    .CLOCK_ENABLE      (1'b1),
    .INPUT_CLK         (i_clk),
    .OUTPUT_CLK        (1'b0),
    .OUTPUT_ENABLE     (1'b0),
    .D_OUT_0           (1'b0),
    .D_OUT_1           (1'b0),
    .D_IN_0            (rise),
    .D_IN_1            (fall)
  );
`else
  always_ff @(posedge i_clk) rise <= i_pin;
  always_ff @(negedge i_clk) fall <= i_pin;
`endif
  always_ff @(posedge i_clk) o_pair <= {rise, fall};
endmodule

// File: rtl/ddr_deser.sv
// ddr_deser: deserialises one DDR data pin into W-bit words, aligning on SYNC_WORD.
//   i_clk     in  1  sole clock, rising edge
//   i_reset   in  1  synchronous active-high reset
//   i_pin     in  1  DDR data pin
//   i_align   in  1  drop lock and re-search
//   o_valid   out 1  one-cycle strobe, o_data holds a new word
//   o_data    out W  received word, first wire bit in MSB
//   o_sync    out 1  o_data equals SYNC_WORD
//   o_locked  out 1  high while locked
//   o_lost    out 1  one-cycle pulse on loss of lock
// Optional loss detection: define DDR_DESER_LOSS_DETECT_EN (adds MAX_GAP parameter);
// without it o_lost is constant 0 and lock holds until i_align or reset.
module ddr_deser
   import ddr_deser_pkg::*;
#(
   parameter int W = 8,
   parameter logic [W-1:0] SYNC_WORD = W'('hB8)
`ifdef DDR_DESER_LOSS_DETECT_EN
   ,
   parameter int MAX_GAP = 64
`endif
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_pin,
   input  logic         i_align,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_sync,
   output logic         o_locked,
   output logic         o_lost
);

   localparam int CW = $clog2(W / 2);

   logic [1:0]    w_pair;
   logic [W-2:0]  r_sr;
   logic [W:0]    w_sr;
   logic          r_phase;
   logic [CW-1:0] r_cnt;
   logic [0:0]    r_state;
   logic          r_valid;
   logic [W-1:0]  r_data;
   logic          r_sync;
   logic          r_lost;
   logic          w_match_a;
   logic          w_match_b;
   logic          w_wrap;
   logic          w_lock;
   logic          w_emit;
   logic          w_is_sync;
   logic          w_lost;
   logic [W-1:0]  w_word;

   iddr_pin u_iddr (
      .i_clk  (i_clk),
      .i_pin  (i_pin),
      .o_pair (w_pair)
   );

   // w_sr is the shift register after this clock's pair is shifted in; only its
   // low W-1 bits need storing, the top two fall off on the next shift.
   always_comb begin
      w_sr      = {r_sr, w_pair};
      w_match_a = w_sr[W-1:0] == SYNC_WORD;
      w_match_b = w_sr[W:1] == SYNC_WORD;
      w_wrap    = r_cnt == CW'(W / 2 - 1);
      w_word    = (r_phase == PHASE_B) ? w_sr[W:1] : w_sr[W-1:0];
      w_is_sync = w_word == SYNC_WORD;
      w_lock    = (r_state == DDR_DESER_SEARCH) && !i_align && (w_match_a || w_match_b);
      w_emit    = (r_state == DDR_DESER_LOCKED) && !i_align && w_wrap;
   end

`ifdef DDR_DESER_LOSS_DETECT_EN
   localparam int GW = $clog2(MAX_GAP + 1);

   logic [GW-1:0] r_gap;

   // Loss fires on the emitted word that brings the gap count to MAX_GAP;
   // w_emit already excludes i_align so an align request wins.
   always_comb w_lost = w_emit && !w_is_sync && (r_gap == GW'(MAX_GAP - 1));

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_gap <= '0;
      else if (w_lock)
         r_gap <= '0;
      else if (w_emit)
         r_gap <= w_is_sync ? '0 : r_gap + GW'(1);
   end
`else
   always_comb w_lost = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sr    <= '0;
         r_phase <= PHASE_A;
         r_cnt   <= '0;
         r_state <= DDR_DESER_SEARCH;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sync  <= 1'b0;
         r_lost  <= 1'b0;
      end else begin
         r_sr    <= w_sr[W-2:0];
         r_valid <= w_lock || w_emit;
         r_lost  <= w_lost;
         if (w_lock) begin
            // Phase A wins when both candidates match.
            r_phase <= w_match_a ? PHASE_A : PHASE_B;
            r_cnt   <= '0;
            r_state <= DDR_DESER_LOCKED;
            r_data  <= SYNC_WORD;
            r_sync  <= 1'b1;
         end else if (w_emit) begin
            r_cnt  <= '0;
            r_data <= w_word;
            r_sync <= w_is_sync;
         end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
         end
         if (i_align || w_lost)
            r_state <= DDR_DESER_SEARCH;
      end
   end

   assign o_valid  = r_valid;
   assign o_data   = r_data;
   assign o_sync   = r_sync;
   assign o_locked = r_state == DDR_DESER_LOCKED;
   assign o_lost   = r_lost;

endmodule

// File: tb/tb_ddr_deser.sv
// tb_ddr_deser: scoreboard bench for ddr_deser (W=8, SYNC_WORD=B8).
module tb_ddr_deser;

   logic       clk = 1'b0;
   logic       rst;
   logic       pin;
   logic       align;
   logic       o_valid;
   logic [7:0] o_data;
   logic       o_sync;
   logic       o_locked;
   logic       o_lost;

   int cyc = 0;
   int last_cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] d;
      logic       s;
      logic       l;
      int         c;
   } exp_t;

   exp_t sb[$];

`ifdef DDR_DESER_LOSS_DETECT_EN
   localparam logic LOSS = 1'b1;
   ddr_deser #(.W(8), .SYNC_WORD(8'hB8), .MAX_GAP(4)) dut (
`else
   localparam logic LOSS = 1'b0;
   ddr_deser #(.W(8), .SYNC_WORD(8'hB8)) dut (
`endif
      .i_clk    (clk),
      .i_reset  (rst),
      .i_pin    (pin),
      .i_align  (align),
      .o_valid  (o_valid),
      .o_data   (o_data),
      .o_sync   (o_sync),
      .o_locked (o_locked),
      .o_lost   (o_lost)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One pin pair per clock: rise bit sampled at posedge, fall bit at the next negedge.
   task automatic send_pair(input logic r, input logic f, input logic a);
      @(negedge clk);
      #1 pin = r;
      align = a;
      @(posedge clk);
      #1 pin = f;
      align = 1'b0;
      last_cyc = cyc;
   endtask

   // Word completed by the last pair sent is expected two posedges later.
   task automatic expect_word(input logic [7:0] d, input logic l);
      sb.push_back('{d, d == 8'hB8, l, last_cyc + 2});
   endtask

   task automatic send_word(input logic [7:0] w, input logic e, input logic l);
      for (int i = 0; i < 4; i++)
         send_pair(w[7-2*i], w[6-2*i], 1'b0);
      if (e)
         expect_word(w, l);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         send_pair(1'b0, 1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_valid) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_word: got %0h want none", o_data);
            end else begin
               e = sb.pop_front();
               chk("word_data", 32'(o_data), 32'(e.d));
               chk("word_sync", 32'(o_sync), 32'(e.s));
               chk("word_cycle", 32'(cyc), 32'(e.c));
               chk("word_lost", 32'(o_lost), 32'(e.l));
            end
         end else if (o_lost) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_lost: got 1 want 0");
         end
      end
   end

   initial begin
      rst = 1'b1;
      pin = 1'b0;
      align = 1'b0;
      // 1: reset with random pin data, then flush the capture pipeline with zeros
      repeat (3) begin
         @(negedge clk);
         pin = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1 pin = 1'($urandom_range(0, 1));
      end
      repeat (3) begin
         @(negedge clk);
         pin = 1'b0;
      end
      @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_data", 32'(o_data), 32'd0);
      chk("rst_sync", 32'(o_sync), 32'd0);
      chk("rst_locked", 32'(o_locked), 32'd0);
      chk("rst_lost", 32'(o_lost), 32'd0);
      rst = 1'b0;
      idle(3);
      chk("search_locked", 32'(o_locked), 32'd0);
      // 2: even-phase lock, B8 then 3C
      send_word(8'hB8, 1'b1, 1'b0);
      send_word(8'h3C, 1'b1, 1'b0);
      chk("even_locked", 32'(o_locked), 32'd1);
      // 4: align on the cycle the 0x55 word would be emitted -> dropped
      send_word(8'h55, 1'b0, 1'b0);
      send_pair(1'b0, 1'b0, 1'b0);
      send_pair(1'b0, 1'b0, 1'b1);
      chk("align_unlocked", 32'(o_locked), 32'd0);
      idle(2);
      send_word(8'h3C, 1'b0, 1'b0);
      idle(3);
      chk("search_hold", 32'(o_locked), 32'd0);
      // 3: odd-phase lock: bits 0, B8, 3C, 0
      send_pair(1'b0, 1'b1, 1'b0);
      send_pair(1'b0, 1'b1, 1'b0);
      send_pair(1'b1, 1'b1, 1'b0);
      send_pair(1'b0, 1'b0, 1'b0);
      send_pair(1'b0, 1'b0, 1'b0);
      expect_word(8'hB8, 1'b0);
      send_pair(1'b0, 1'b1, 1'b0);
      send_pair(1'b1, 1'b1, 1'b0);
      send_pair(1'b1, 1'b0, 1'b0);
      send_pair(1'b0, 1'b0, 1'b0);
      expect_word(8'h3C, 1'b0);
      chk("odd_locked", 32'(o_locked), 32'd1);
      idle(2);
      send_pair(1'b0, 1'b0, 1'b1);
      idle(4);
      chk("odd_realigned", 32'(o_locked), 32'd0);
      // 5/6: four non-sync words after lock
      send_word(8'hB8, 1'b1, 1'b0);
      send_word(8'h00, 1'b1, 1'b0);
      send_word(8'h00, 1'b1, 1'b0);
      send_word(8'h00, 1'b1, 1'b0);
      send_word(8'h00, 1'b1, LOSS);
      idle(2);
      chk("gap_locked", 32'(o_locked), LOSS ? 32'd0 : 32'd1);
      send_pair(1'b0, 1'b0, 1'b1);
      idle(4);
      chk("gap_realigned", 32'(o_locked), 32'd0);
      // sync word as third of four keeps lock in either build
      send_word(8'hB8, 1'b1, 1'b0);
      send_word(8'h00, 1'b1, 1'b0);
      send_word(8'h00, 1'b1, 1'b0);
      send_word(8'hB8, 1'b1, 1'b0);
      send_word(8'h00, 1'b1, 1'b0);
      idle(2);
      chk("sync_kept_locked", 32'(o_locked), 32'd1);
      send_pair(1'b0, 1'b0, 1'b1);
      idle(6);
      chk("final_unlocked", 32'(o_locked), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
